// File: rtl/inst_rom_arbiter_pkg.sv
// Shared constants for the instruction ROM arbiter.
// ROM enable levels, port tags and an alignment helper.
package inst_rom_arbiter_pkg;

  localparam logic READ_ENABLE  = 1'b1;
  localparam logic READ_DISABLE = 1'b0;

  localparam logic ROM_PORT0 = 1'b0;
  localparam logic ROM_PORT1 = 1'b1;

  localparam int WCNT_W = 4;

  function automatic logic is_misaligned(
    input logic [1:0] lsb
  );
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/rom_wait_cnt.sv
// Saturating starvation counter for the debug port.
// Ports: clk_i, rst_i, inc_i, clr_i in; at_max_o high when count == MAX_WAIT.
module rom_wait_cnt
  import inst_rom_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam logic [WCNT_W-1:0] MAX_V = WCNT_W'(MAX_WAIT);

  logic [WCNT_W-1:0] cnt_q;
  logic [WCNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MAX_V);

endmodule

// File: rtl/inst_rom_arbiter.sv
// Two-port arbiter in front of a combinational-read instruction ROM.
// Port 0 = IF fetch, port 1 = debug read; one access per cycle, response
// (rvalid0/rvalid1, rdata, rerr) registered one cycle after gnt0/gnt1.
// ROM side: rom_ce, rom_addr out, rom_inst in.
module inst_rom_arbiter
  import inst_rom_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  logic              at_max;
  logic              win0;
  logic              win1;
  logic              any_win;
  logic              mis;
  logic [ADDR_W-1:0] sel_addr;

  logic              valid_q, valid_d;
  logic              port_q, port_d;
  logic              rerr_q, rerr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  rom_wait_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_cnt (
    .clk_i    (clk),
    .rst_i    (rst),
    .inc_i    (req1 && !win1),
    .clr_i    (!req1 || win1),
    .at_max_o (at_max)
  );

  // Port 0 has priority until port 1 has been starved MAX_WAIT cycles.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (!rst) begin
      if (req1 && (!req0 || at_max)) begin
        win1 = 1'b1;
      end else if (req0) begin
        win0 = 1'b1;
      end
    end
  end

  assign any_win  = win0 || win1;
  assign sel_addr = win1 ? addr1 : addr0;
  assign mis      = is_misaligned(sel_addr[1:0]);

  always_comb begin
    rom_ce   = READ_DISABLE;
    rom_addr = '0;
    if (any_win && !mis) begin
      rom_ce   = READ_ENABLE;
      rom_addr = sel_addr;
    end
  end

  // Data and error hold between grants; only valid drops.
  always_comb begin
    valid_d = any_win;
    port_d  = port_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    if (any_win) begin
      port_d  = win1 ? ROM_PORT1 : ROM_PORT0;
      rdata_d = mis ? '0 : rom_inst;
      rerr_d  = mis;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      port_q  <= ROM_PORT0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      port_q  <= port_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  assign gnt0    = win0;
  assign gnt1    = win1;
  assign rvalid0 = valid_q && (port_q == ROM_PORT0);
  assign rvalid1 = valid_q && (port_q == ROM_PORT1);
  assign rdata   = rdata_q;
  assign rerr    = rerr_q;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Testbench for inst_rom_arbiter: directed literal cases plus
// randomized traffic checked against a cycle model every cycle.
module tb_inst_rom_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        gnt0, gnt1, rvalid0, rvalid1, rerr, rom_ce;
  logic [31:0] rdata, rom_addr, rom_inst;

  logic [31:0] rom_mem [64];

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int          m_wait = 0;
  logic        m_gnt0 = 1'b0, m_gnt1 = 1'b0;
  logic        e_v0 = 1'b0, e_v1 = 1'b0, e_rerr = 1'b0;
  logic [31:0] e_rdata = '0;

  always #5 clk = ~clk;

  assign rom_inst = rom_mem[rom_addr[7:2]];

  inst_rom_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (MAXW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .addr0    (addr0),
    .gnt0     (gnt0),
    .rvalid0  (rvalid0),
    .req1     (req1),
    .addr1    (addr1),
    .gnt1     (gnt1),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .rerr     (rerr),
    .rom_ce   (rom_ce),
    .rom_addr (rom_addr),
    .rom_inst (rom_inst)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle model: priority to port 0 unless port 1 has waited MAXW cycles.
  always @(negedge clk) begin
    logic        g0, g1, mis;
    logic [31:0] a;
    if (rst) begin
      m_wait  = 0;
      m_gnt0  = 1'b0;
      m_gnt1  = 1'b0;
      e_v0    = 1'b0;
      e_v1    = 1'b0;
      e_rdata = '0;
      e_rerr  = 1'b0;
      chk("rst_gnt0", 32'(gnt0), 0);
      chk("rst_gnt1", 32'(gnt1), 0);
      chk("rst_ce", 32'(rom_ce), 0);
      chk("rst_raddr", rom_addr, 0);
      chk("rst_rv0", 32'(rvalid0), 0);
      chk("rst_rv1", 32'(rvalid1), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_rerr", 32'(rerr), 0);
    end else begin
      chk("m_rv0", 32'(rvalid0), 32'(e_v0));
      chk("m_rv1", 32'(rvalid1), 32'(e_v1));
      chk("m_rdata", rdata, e_rdata);
      chk("m_rerr", 32'(rerr), 32'(e_rerr));
      g1  = req1 && (!req0 || m_wait == MAXW);
      g0  = req0 && !g1;
      a   = g1 ? addr1 : addr0;
      mis = (a % 4) != 0;
      chk("m_gnt0", 32'(gnt0), 32'(g0));
      chk("m_gnt1", 32'(gnt1), 32'(g1));
      chk("m_ce", 32'(rom_ce), 32'((g0 || g1) && !mis));
      chk("m_raddr", rom_addr, ((g0 || g1) && !mis) ? a : 32'd0);
      e_v0 = g0;
      e_v1 = g1;
      if (g0 || g1) begin
        e_rdata = mis ? 32'd0 : rom_mem[(a / 4) % 64];
        e_rerr  = mis;
      end
      if (req1 && !g1) m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
      else m_wait = 0;
      m_gnt0 = g0;
      m_gnt1 = g1;
    end
  end

  task automatic drive(input logic r0, input logic [31:0] a0,
                       input logic r1, input logic [31:0] a1);
    @(posedge clk);
    #1;
    req0  = r0;
    addr0 = a0;
    req1  = r1;
    addr1 = a1;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = ($urandom % 64) * 4;
    if ($urandom % 8 == 0) a = a | ($urandom_range(1, 3));
    if ($urandom % 4 == 0) a = a | ($urandom & 32'hFFFF_FF00);
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
    rom_mem[0] = 32'h3c01_0000;
    rom_mem[1] = 32'h2021_0004;
    rom_mem[2] = 32'h3401_1100;
    rst   = 1'b1;
    req0  = 1'b1;
    req1  = 1'b1;
    addr0 = 32'h0;
    addr1 = 32'h0;

    // reset holds everything off even with both requesting
    @(negedge clk);
    chk("reset_gnt0", 32'(gnt0), 0);
    chk("reset_gnt1", 32'(gnt1), 0);
    chk("reset_ce", 32'(rom_ce), 0);
    chk("reset_rdata", rdata, 32'h0);
    #1 rst = 1'b0;
    #1 chk("first_gnt0", 32'(gnt0), 1);
    req0 = 1'b0;
    req1 = 1'b0;

    // single aligned read
    drive(1, 32'h8, 0, 0);
    @(negedge clk);
    chk("single_gnt0", 32'(gnt0), 1);
    chk("single_raddr", rom_addr, 32'h8);
    chk("single_ce", 32'(rom_ce), 1);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("single_rv0", 32'(rvalid0), 1);
    chk("single_rdata", rdata, 32'h3401_1100);
    chk("single_rerr", 32'(rerr), 0);

    // starvation: port 1 wins at cycles 4 and 9
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'(i * 4), 1, 32'h40);
      @(negedge clk);
      chk("starve_gnt1", 32'(gnt1), 32'(i == 4 || i == 9));
      chk("starve_gnt0", 32'(gnt0), 32'(!(i == 4 || i == 9)));
    end

    // misaligned debug read
    drive(0, 0, 1, 32'h6);
    @(negedge clk);
    chk("mis_gnt1", 32'(gnt1), 1);
    chk("mis_ce", 32'(rom_ce), 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("mis_rv1", 32'(rvalid1), 1);
    chk("mis_rerr", 32'(rerr), 1);
    chk("mis_rdata", rdata, 32'h0);

    // back-to-back fetches
    drive(1, 32'h0, 0, 0);
    @(negedge clk);
    drive(1, 32'h4, 0, 0);
    @(negedge clk);
    chk("b2b_rv0_0", 32'(rvalid0), 1);
    chk("b2b_w0", rdata, 32'h3c01_0000);
    drive(1, 32'h8, 0, 0);
    @(negedge clk);
    chk("b2b_rv0_1", 32'(rvalid0), 1);
    chk("b2b_w1", rdata, 32'h2021_0004);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_rv0_2", 32'(rvalid0), 1);
    chk("b2b_w2", rdata, 32'h3401_1100);

    // reset mid-access with port 1 partly starved
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0, 1, 32'h10);
      @(negedge clk);
    end
    #1;
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_rv0", 32'(rvalid0), 0);
    chk("rstmid_rv1", 32'(rvalid1), 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h0, 1, 32'h10);
      @(negedge clk);
      chk("rstmid_cnt", 32'(gnt1), 32'(i == 4));
    end

    // randomized traffic following the hold-until-grant protocol
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (rst) rst = 1'b0;
      else if ($urandom % 400 == 0) rst = 1'b1;
      if (!req0 || m_gnt0) begin
        req0  = ($urandom % 4) != 0;
        addr0 = rnd_addr();
      end else if ($urandom % 16 == 0) begin
        req0 = 1'b0;
      end
      if (!req1 || m_gnt1) begin
        req1  = ($urandom % 2) != 0;
        addr1 = rnd_addr();
      end else if ($urandom % 16 == 0) begin
        req1 = 1'b0;
      end
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_rom_arbiter.md
Name: inst_rom_arbiter

Overview:
- Shares the single-port, combinational-read instruction ROM between two requesters: port 0 is the IF-stage fetch and port 1 is the debug/loader read.
- Drives the ROM chip-enable and address, registers the returned word, and returns it to the winning requester one cycle later.
- Sits between the pipeline fetch logic and the instruction ROM in the top-level SoC wrapper.

Parameters:
- ADDR_W, 32, byte-address width; matches InstAddrBus.
- DATA_W, 32, instruction word width; matches InstBus.
- MAX_WAIT, 4, consecutive cycles port 1 may be denied before it takes priority; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req0  in  1  port 0 (IF) request.
- addr0  in  ADDR_W  port 0 byte address.
- gnt0  out  1  port 0 request accepted this cycle.
- rvalid0  out  1  port 0 read data valid.
- req1  in  1  port 1 (debug) request.
- addr1  in  ADDR_W  port 1 byte address.
- gnt1  out  1  port 1 request accepted this cycle.
- rvalid1  out  1  port 1 read data valid.
- rdata  out  DATA_W  registered read word, shared by both ports.
- rerr  out  1  response is a misalignment error; qualified by rvalid0/rvalid1.
- rom_ce  out  1  ROM chip enable; ReadEnable or ReadDisable.
- rom_addr  out  ADDR_W  ROM byte address.
- rom_inst  in  DATA_W  ROM combinational read data.

Behaviour:
- Reset, asserted asynchronously:
  - rvalid0, rvalid1, rerr = 0; rdata = ZeroWord; wait counter = 0.
  - gnt0, gnt1, rom_ce are forced 0 while rst = 1; rom_addr = 0.
- Arbitration is combinational in cycle N:
  - Only req0: gnt0 = 1.
  - Only req1: gnt1 = 1.
  - Both requesting: port 0 wins unless wcnt == MAX_WAIT, in which case port 1 wins.
  - At most one grant per cycle.
- Requester protocol: hold req and addr stable until gnt. A request may be dropped before grant; it is then lost with no response.
- Memory access in grant cycle N:
  - Aligned address (addr[1:0] == 0): rom_ce = ReadEnable, rom_addr = winner's addr.
  - No grant, or misaligned address: rom_ce = ReadDisable, rom_addr = 0.
- Response in cycle N+1:
  - Exactly one of rvalid0/rvalid1 is high, matching the cycle-N grant.
  - rdata = rom_inst sampled at the N→N+1 edge.
  - Misaligned: rdata = ZeroWord, rerr = 1. Otherwise rerr = 0.
  - With no grant in cycle N: both rvalid = 0, and rdata/rerr hold their last value.
- Latency and throughput:
  - Fixed latency of 1 cycle; throughput of 1 access per cycle.
  - Back-to-back grants to either port are allowed; rdata updates every granted cycle.
- Wait counter (4 bits, saturating at MAX_WAIT):
  - +1 on each cycle with req1 = 1 and gnt1 = 0.
  - Cleared on gnt1 = 1 or req1 = 0.
  - Never exceeds MAX_WAIT.
- Boundary conditions:
  - MAX_WAIT = 1: port 1 waits at most one cycle under continuous port-0 traffic.
  - A forced port-1 win and a port-1 misaligned address in the same cycle: grant still given, error response returned, counter cleared.
  - Reset mid-access: a pending rvalid is cancelled and no response is issued after reset deasserts.
  - The first grant is possible in the first cycle after rst falls.
  - addr bits above ROM depth are passed through; decoding is the ROM's job.

Decomposition:
- defines.v (shared, existing): ReadEnable, ReadDisable, ZeroWord, InstAddrBus, InstBus. Add RomPort0 = 1'b0 and RomPort1 = 1'b1 for the registered last-winner tag.
- One sub-module is natural: rom_wait_cnt, the saturating starvation counter with inputs inc/clr and output at_max.
- Arbitration and response registers stay in the top block.

Test Plan:
- Reset: hold rst = 1 with req0 = req1 = 1 → gnt0 = gnt1 = rom_ce = 0, rdata = 0x00000000; after release, gnt0 = 1 in the first cycle.
- Single read: req0 = 1, addr0 = 0x00000008, ROM word[2] = 0x34011100 → cycle N gnt0 = 1, rom_addr = 0x8, rom_ce = 1; cycle N+1 rvalid0 = 1, rdata = 0x34011100, rerr = 0.
- Contention/starvation: req0 = 1 every cycle, req1 = 1 from cycle 0, MAX_WAIT = 4 → gnt0 in cycles 0–3, gnt1 in cycle 4, gnt0 in cycles 5–8, gnt1 in cycle 9.
- Misaligned: req1 = 1, addr1 = 0x00000006 → gnt1 = 1, rom_ce = 0; next cycle rvalid1 = 1, rerr = 1, rdata = 0.
- Back-to-back: alternate addr0 = 0x0, 0x4, 0x8 on consecutive cycles → rvalid0 high for 3 cycles, rdata = words 0, 1, 2 in order.
- Reset mid-access: grant in cycle N, rst pulsed before edge N+1 → no rvalid after release, wait counter = 0.
